// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one synchronous-read data-memory port between
// the core (master 0) and a secondary requester (master 1).
// Ports: clk_i, rst_ni (async, active low); per master mN_req_i/we_i/addr_i/
// wdata_i in, mN_gnt_o/rvalid_o/rdata_o out; memory side mem_we_o/addr_o/
// wdata_o out, mem_rdata_i in; status busy_o, owner_o.
// Build macro DMEM_ARB_RR_EN: round-robin arbitration instead of fixed
// priority with the STARVE_LIMIT starvation guard.
module dmem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          m0_req_i,
   input  logic          m0_we_i,
   input  logic [AW-1:0] m0_addr_i,
   input  logic [DW-1:0] m0_wdata_i,
   output logic          m0_gnt_o,
   output logic          m0_rvalid_o,
   output logic [DW-1:0] m0_rdata_o,
   input  logic          m1_req_i,
   input  logic          m1_we_i,
   input  logic [AW-1:0] m1_addr_i,
   input  logic [DW-1:0] m1_wdata_i,
   output logic          m1_gnt_o,
   output logic          m1_rvalid_o,
   output logic [DW-1:0] m1_rdata_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          busy_o,
   output logic          owner_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nx;
   logic          w_any_req;
   logic          w_arb;
   logic          w_win;

   logic          r_m0_gnt;
   logic          r_m1_gnt;
   logic          r_m0_rvalid;
   logic          r_m1_rvalid;
   logic [DW-1:0] r_m0_rdata;
   logic [DW-1:0] r_m1_rdata;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic          r_is_wr;
   logic          r_owner;

   assign w_any_req = m0_req_i | m1_req_i;

`ifdef DMEM_ARB_RR_EN
   // r_last holds the previous winner; reset to 1 so master 0 wins first tie.
   logic r_last;

   assign w_win = m1_req_i & (~m0_req_i | ~r_last);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last <= 1'b1;
      end else if (w_arb) begin
         r_last <= w_win;
      end
   end
`else
   localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

   // Counts master-0 wins while master 1 waits; at the limit master 1 is
   // forced through, so the counter never passes LP_LIMIT.
   logic [3:0] r_starve;

   assign w_win = m1_req_i & (~m0_req_i | (r_starve == LP_LIMIT));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_starve <= '0;
      end else if (w_arb) begin
         if (w_win || !m1_req_i) begin
            r_starve <= '0;
         end else begin
            r_starve <= r_starve + 4'd1;
         end
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_arb      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_arb      = 1'b1;
               w_state_nx = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_state_nx = S_RESP;
         end
         S_RESP: begin
            // Back-to-back: the next command issues on the response edge.
            if (w_any_req) begin
               w_arb      = 1'b1;
               w_state_nx = S_ISSUE;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_m0_gnt    <= 1'b0;
         r_m1_gnt    <= 1'b0;
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
         r_m0_rdata  <= '0;
         r_m1_rdata  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_is_wr     <= 1'b0;
         r_owner     <= 1'b0;
      end else begin
         r_m0_gnt    <= 1'b0;
         r_m1_gnt    <= 1'b0;
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
         if (r_state == S_ISSUE) begin
            r_mem_we <= 1'b0;
         end
         // Response goes to the old owner even if a new grant lands now.
         if (r_state == S_RESP) begin
            if (r_owner) begin
               r_m1_rvalid <= 1'b1;
               if (!r_is_wr) begin
                  r_m1_rdata <= mem_rdata_i;
               end
            end else begin
               r_m0_rvalid <= 1'b1;
               if (!r_is_wr) begin
                  r_m0_rdata <= mem_rdata_i;
               end
            end
         end
         if (w_arb) begin
            r_owner     <= w_win;
            r_m0_gnt    <= ~w_win;
            r_m1_gnt    <= w_win;
            r_mem_we    <= w_win ? m1_we_i : m0_we_i;
            r_is_wr     <= w_win ? m1_we_i : m0_we_i;
            r_mem_addr  <= w_win ? m1_addr_i : m0_addr_i;
            r_mem_wdata <= w_win ? m1_wdata_i : m0_wdata_i;
         end
      end
   end

   assign m0_gnt_o    = r_m0_gnt;
   assign m1_gnt_o    = r_m1_gnt;
   assign m0_rvalid_o = r_m0_rvalid;
   assign m1_rvalid_o = r_m1_rvalid;
   assign m0_rdata_o  = r_m0_rdata;
   assign m1_rdata_o  = r_m1_rdata;
   assign mem_we_o    = r_mem_we;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign busy_o      = (r_state != S_IDLE);
   assign owner_o     = r_owner;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed bench for dmem_port_arbiter with a
// synchronous-read memory model and hand-computed expected values.
module tb_dmem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          m0_req_i = 1'b0;
   logic          m0_we_i = 1'b0;
   logic [AW-1:0] m0_addr_i = '0;
   logic [DW-1:0] m0_wdata_i = '0;
   logic          m0_gnt_o;
   logic          m0_rvalid_o;
   logic [DW-1:0] m0_rdata_o;
   logic          m1_req_i = 1'b0;
   logic          m1_we_i = 1'b0;
   logic [AW-1:0] m1_addr_i = '0;
   logic [DW-1:0] m1_wdata_i = '0;
   logic          m1_gnt_o;
   logic          m1_rvalid_o;
   logic [DW-1:0] m1_rdata_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;
   logic          busy_o;
   logic          owner_o;

   int n_vec = 0;
   int n_err = 0;

   dmem_port_arbiter #(
      .AW(AW),
      .DW(DW),
      .STARVE_LIMIT(4)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_ni),
      .m0_req_i(m0_req_i),
      .m0_we_i(m0_we_i),
      .m0_addr_i(m0_addr_i),
      .m0_wdata_i(m0_wdata_i),
      .m0_gnt_o(m0_gnt_o),
      .m0_rvalid_o(m0_rvalid_o),
      .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i),
      .m1_we_i(m1_we_i),
      .m1_addr_i(m1_addr_i),
      .m1_wdata_i(m1_wdata_i),
      .m1_gnt_o(m1_gnt_o),
      .m1_rvalid_o(m1_rvalid_o),
      .m1_rdata_o(m1_rdata_o),
      .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o),
      .owner_o(owner_o)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
      if (a == 32'h100) return 32'hDEAD_BEEF;
      return a ^ 32'hC0DE_0000;
   endfunction

   // Synchronous-read memory: data valid the cycle after the address.
   logic [DW-1:0] wmem [logic [9:0]];
   always @(posedge clk) begin
      logic [9:0] idx;
      idx = mem_addr_o[11:2];
      if (wmem.exists(idx)) mem_rdata_i <= wmem[idx];
      else mem_rdata_i <= init_word(mem_addr_o);
      if (mem_we_o) wmem[idx] = mem_wdata_o;
   end

   // Free-running event counters; scenarios compare deltas.
   int cnt_we = 0;
   int cnt_rv0 = 0;
   int cnt_rv1 = 0;
   int cnt_g1 = 0;
   int cnt_hit = 0;
   always @(posedge clk) begin
      #1;
      if (mem_we_o) cnt_we <= cnt_we + 1;
      if (m0_rvalid_o) cnt_rv0 <= cnt_rv0 + 1;
      if (m1_rvalid_o) cnt_rv1 <= cnt_rv1 + 1;
      if (m1_gnt_o) cnt_g1 <= cnt_g1 + 1;
      if (busy_o && mem_addr_o == 32'h200) cnt_hit <= cnt_hit + 1;
   end

   task automatic test_reset;
      rst_ni = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o} !== 4'b0) begin
         n_err++;
         $display("FAIL reset_pulses: got %b expected 0000",
                  {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o});
      end
      n_vec++;
      if (m0_rdata_o !== 32'h0 || m1_rdata_o !== 32'h0) begin
         n_err++;
         $display("FAIL reset_rdata: got %h/%h expected 0/0",
                  m0_rdata_o, m1_rdata_o);
      end
      n_vec++;
      if ({mem_we_o, mem_addr_o, mem_wdata_o} !== 65'h0) begin
         n_err++;
         $display("FAIL reset_mem: got we=%b a=%h d=%h expected 0",
                  mem_we_o, mem_addr_o, mem_wdata_o);
      end
      n_vec++;
      if ({busy_o, owner_o} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_status: got %b expected 00", {busy_o, owner_o});
      end
      rst_ni = 1'b1;
      @(negedge clk);
      n_vec++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: got busy=%b expected 0", busy_o);
      end
   endtask

   task automatic test_single_read;
      @(negedge clk);
      m1_req_i = 1'b1;
      m1_we_i = 1'b0;
      m1_addr_i = 32'h100;
      @(negedge clk);
      n_vec++;
      if ({m1_gnt_o, m0_gnt_o, owner_o, busy_o, mem_we_o} !== 5'b10110) begin
         n_err++;
         $display("FAIL rd_gnt: got g1,g0,own,busy,we=%b expected 10110",
                  {m1_gnt_o, m0_gnt_o, owner_o, busy_o, mem_we_o});
      end
      n_vec++;
      if (mem_addr_o !== 32'h100) begin
         n_err++;
         $display("FAIL rd_addr: got %h expected 00000100", mem_addr_o);
      end
      m1_req_i = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({m1_gnt_o, m1_rvalid_o, owner_o} !== 3'b001) begin
         n_err++;
         $display("FAIL rd_wait: got g1,rv1,own=%b expected 001",
                  {m1_gnt_o, m1_rvalid_o, owner_o});
      end
      @(negedge clk);
      n_vec++;
      if ({m1_rvalid_o, m0_rvalid_o, owner_o} !== 3'b101) begin
         n_err++;
         $display("FAIL rd_rvalid: got rv1,rv0,own=%b expected 101",
                  {m1_rvalid_o, m0_rvalid_o, owner_o});
      end
      n_vec++;
      if (m1_rdata_o !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL rd_data: got %h expected deadbeef", m1_rdata_o);
      end
      @(negedge clk);
      n_vec++;
      if ({m1_rvalid_o, busy_o} !== 2'b00 || m1_rdata_o !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL rd_hold: got rv1=%b busy=%b d=%h expected 0 0 deadbeef",
                  m1_rvalid_o, busy_o, m1_rdata_o);
      end
   endtask

   task automatic test_write_readback;
      int we0;
      @(negedge clk);
      we0 = cnt_we;
      m0_req_i = 1'b1;
      m0_we_i = 1'b1;
      m0_addr_i = 32'h40;
      m0_wdata_i = 32'h0000_1234;
      @(negedge clk);
      n_vec++;
      if ({m0_gnt_o, mem_we_o, owner_o} !== 3'b110 ||
          mem_wdata_o !== 32'h0000_1234) begin
         n_err++;
         $display("FAIL wr_issue: got g0,we,own=%b d=%h expected 110 00001234",
                  {m0_gnt_o, mem_we_o, owner_o}, mem_wdata_o);
      end
      m0_we_i = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({mem_we_o, m0_rvalid_o} !== 2'b00) begin
         n_err++;
         $display("FAIL wr_resp: got we,rv0=%b expected 00",
                  {mem_we_o, m0_rvalid_o});
      end
      @(negedge clk);
      n_vec++;
      if ({m0_rvalid_o, m0_gnt_o, mem_we_o} !== 3'b110) begin
         n_err++;
         $display("FAIL wr_b2b: got rv0,g0,we=%b expected 110",
                  {m0_rvalid_o, m0_gnt_o, mem_we_o});
      end
      m0_req_i = 1'b0;
      @(negedge clk);
      n_vec++;
      if (m0_rvalid_o !== 1'b0) begin
         n_err++;
         $display("FAIL wr_gap: got rv0=%b expected 0", m0_rvalid_o);
      end
      @(negedge clk);
      n_vec++;
      if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'h0000_1234) begin
         n_err++;
         $display("FAIL wr_readback: got rv0=%b d=%h expected 1 00001234",
                  m0_rvalid_o, m0_rdata_o);
      end
      n_vec++;
      if (cnt_we - we0 !== 1) begin
         n_err++;
         $display("FAIL wr_we_cycles: got %0d expected 1", cnt_we - we0);
      end
   endtask

   task automatic test_arbitration;
      int q[$];
`ifdef DMEM_ARB_RR_EN
      int exp_seq [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
      int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
      @(negedge clk);
      rst_ni = 1'b0;
      #1;
      rst_ni = 1'b1;
      m0_req_i = 1'b1;
      m0_we_i = 1'b0;
      m0_addr_i = 32'h300;
      m1_req_i = 1'b1;
      m1_we_i = 1'b0;
      m1_addr_i = 32'h304;
      for (int c = 0; c < 40 && q.size() < 10; c++) begin
         @(negedge clk);
         if (m0_gnt_o) q.push_back(0);
         if (m1_gnt_o) q.push_back(1);
         if (m0_gnt_o && m1_gnt_o) begin
            n_vec++;
            n_err++;
            $display("FAIL arb_double_gnt: got both gnt expected one");
         end
         if (m0_rvalid_o) begin
            n_vec++;
            if (m0_rdata_o !== 32'hC0DE_0300) begin
               n_err++;
               $display("FAIL arb_rdata0: got %h expected c0de0300", m0_rdata_o);
            end
         end
         if (m1_rvalid_o) begin
            n_vec++;
            if (m1_rdata_o !== 32'hC0DE_0304) begin
               n_err++;
               $display("FAIL arb_rdata1: got %h expected c0de0304", m1_rdata_o);
            end
         end
      end
      m0_req_i = 1'b0;
      m1_req_i = 1'b0;
      n_vec++;
      if (q.size() != 10) begin
         n_err++;
         $display("FAIL arb_count: got %0d grants expected 10", q.size());
      end
      for (int i = 0; i < q.size(); i++) begin
         n_vec++;
         if (q[i] != exp_seq[i]) begin
            n_err++;
            $display("FAIL arb_order[%0d]: got m%0d expected m%0d",
                     i, q[i], exp_seq[i]);
         end
      end
      for (int c = 0; c < 10 && busy_o; c++) @(negedge clk);
      n_vec++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL arb_drain: got busy=%b expected 0", busy_o);
      end
   endtask

   task automatic test_withdrawn;
      int g1;
      int hit;
      int rv0;
      @(negedge clk);
      g1 = cnt_g1;
      hit = cnt_hit;
      rv0 = cnt_rv0;
      m0_req_i = 1'b1;
      m0_we_i = 1'b0;
      m0_addr_i = 32'h500;
      @(negedge clk);
      n_vec++;
      if (m0_gnt_o !== 1'b1) begin
         n_err++;
         $display("FAIL wd_m0_gnt: got %b expected 1", m0_gnt_o);
      end
      m0_req_i = 1'b0;
      m1_req_i = 1'b1;
      m1_we_i = 1'b0;
      m1_addr_i = 32'h200;
      @(negedge clk);
      m1_req_i = 1'b0;
      repeat (4) @(negedge clk);
      n_vec++;
      if (cnt_g1 - g1 !== 0) begin
         n_err++;
         $display("FAIL wd_m1_gnt: got %0d grants expected 0", cnt_g1 - g1);
      end
      n_vec++;
      if (cnt_hit - hit !== 0) begin
         n_err++;
         $display("FAIL wd_mem_access: got %0d cycles at 200 expected 0",
                  cnt_hit - hit);
      end
      n_vec++;
      if (cnt_rv0 - rv0 !== 1 || m0_rdata_o !== 32'hC0DE_0500) begin
         n_err++;
         $display("FAIL wd_m0_done: got rv=%0d d=%h expected 1 c0de0500",
                  cnt_rv0 - rv0, m0_rdata_o);
      end
      n_vec++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL wd_idle: got busy=%b expected 0", busy_o);
      end
   endtask

   task automatic test_reset_mid_access;
      int rv;
      @(negedge clk);
      m0_req_i = 1'b1;
      m0_we_i = 1'b1;
      m0_addr_i = 32'h80;
      m0_wdata_i = 32'h5555_AAAA;
      @(negedge clk);
      n_vec++;
      if (mem_we_o !== 1'b1) begin
         n_err++;
         $display("FAIL rst_issue_we: got %b expected 1", mem_we_o);
      end
      rv = cnt_rv0 + cnt_rv1;
      m0_req_i = 1'b0;
      m0_we_i = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      n_vec++;
      if ({mem_we_o, busy_o, m0_gnt_o} !== 3'b000) begin
         n_err++;
         $display("FAIL rst_async: got we,busy,g0=%b expected 000",
                  {mem_we_o, busy_o, m0_gnt_o});
      end
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      n_vec++;
      if (cnt_rv0 + cnt_rv1 - rv !== 0) begin
         n_err++;
         $display("FAIL rst_no_rvalid: got %0d pulses expected 0",
                  cnt_rv0 + cnt_rv1 - rv);
      end
      n_vec++;
      if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, mem_we_o,
           busy_o, owner_o} !== 7'b0 || mem_addr_o !== 32'h0 ||
          mem_wdata_o !== 32'h0 || m0_rdata_o !== 32'h0 ||
          m1_rdata_o !== 32'h0) begin
         n_err++;
         $display("FAIL rst_outputs: got ctl=%b a=%h d=%h r0=%h r1=%h expected 0",
                  {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, mem_we_o,
                   busy_o, owner_o}, mem_addr_o, mem_wdata_o,
                  m0_rdata_o, m1_rdata_o);
      end
      m1_req_i = 1'b1;
      m1_we_i = 1'b0;
      m1_addr_i = 32'h100;
      @(negedge clk);
      n_vec++;
      if ({m1_gnt_o, owner_o} !== 2'b11) begin
         n_err++;
         $display("FAIL rst_new_gnt: got g1,own=%b expected 11",
                  {m1_gnt_o, owner_o});
      end
      m1_req_i = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL rst_new_read: got rv1=%b d=%h expected 1 deadbeef",
                  m1_rvalid_o, m1_rdata_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_readback();
      test_arbitration();
      test_withdrawn();
      test_reset_mid_access();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter that shares the core's single data-memory port between the multi-cycle core (master 0) and a secondary requester such as a loader, DMA or debug agent (master 1). It takes one request at a time, drives the memory command for exactly one cycle and returns read data and a completion pulse to the winning master. It sits between the masters and the synchronous-read data memory.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `STARVE_LIMIT`, 4, consecutive master-0 wins after which a waiting master 1 is forced through. Fixed-priority build only. Range 1..15.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: asynchronous active-low reset.
- `m0_req_i`, `m1_req_i` in 1: access request.
- `m0_we_i`, `m1_we_i` in 1: 1 = write, 0 = read.
- `m0_addr_i`, `m1_addr_i` in AW: byte address, passed through unmodified.
- `m0_wdata_i`, `m1_wdata_i` in DW: write data.
- `m0_gnt_o`, `m1_gnt_o` out 1: one-cycle pulse; the command was accepted.
- `m0_rvalid_o`, `m1_rvalid_o` out 1: one-cycle completion pulse. Asserted for reads and writes.
- `m0_rdata_o`, `m1_rdata_o` out DW: read data. Valid with rvalid and held until the next read completes for that master.
- `mem_we_o` out 1: memory write enable.
- `mem_addr_o` out AW: memory address.
- `mem_wdata_o` out DW: memory write data.
- `mem_rdata_i` in DW: memory read data, valid the cycle after the address is presented.
- `busy_o` out 1: high in ISSUE and RESP.
- `owner_o` out 1: master that owns the current access.

## Operation
FSM states: IDLE, ISSUE, RESP.

- **IDLE:** if any request is high, arbitrate. On the clock edge:
  - latch the winner's we/addr/wdata into `mem_*_o`;
  - set `owner_o` to the winner;
  - pulse the winner's gnt;
  - go to ISSUE.
  With no request, remain in IDLE with `mem_we_o`=0.
- **ISSUE:** the memory samples the command. On the edge: `mem_we_o`←0, go to RESP. `mem_addr_o` holds.
- **RESP:**
  - On the edge, pulse the owner's rvalid.
  - If the access was a read, load `mem_rdata_i` into the owner's rdata.
  - If any request is high, arbitrate and issue the next command in the same edge (RESP→ISSUE with a new gnt). Otherwise go to IDLE.
- **Requester rules:**
  - Hold req and the command stable until gnt.
  - The command is sampled only on the gnt edge.
  - Req may stay high after gnt to request another access; that is a new, independent request.
  - A master never sees gnt and rvalid in the same cycle for the same access.
- **Arbitration, fixed priority (default build):**
  - Master 0 wins ties.
  - A 4-bit starve counter increments each time master 0 wins while `m1_req_i` is high.
  - When the counter equals `STARVE_LIMIT`, master 1 wins the next arbitration if it is requesting.
  - The counter clears whenever master 1 wins or `m1_req_i` is low at an arbitration.
- Requests at an address are never merged or reordered. There is one access in flight at most.

## Timing
- **Reset:** all outputs 0, state IDLE, starve counter 0, round-robin pointer favours master 0. Reset is asynchronous, so `mem_we_o` drops immediately.
- **Reset mid-access:** the in-flight access is abandoned. No gnt or rvalid follows, and a write already in ISSUE may or may not have landed.
- **Latency:** request first seen in IDLE at edge T → gnt in cycle T+1 (ISSUE) → rvalid and rdata in cycle T+3.
- **Throughput:** one access per 2 cycles under continuous requests.
- `mem_we_o` is high for exactly one cycle per write and never during RESP or IDLE.
- **Request withdrawn before gnt:** the request is dropped silently and no access is issued. This is legal, but the command is not sampled unless req is high at the arbitration edge.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - Round-robin arbitration. On a tie, the master that did not win last arbitration wins.
  - A pointer updates on every grant.
  - The starve counter and `STARVE_LIMIT` are not built.
- `DMEM_ARB_RR_EN` undefined: fixed priority with the starvation guard, as described above.

## Test plan
- **Single read:** m1 reads 0x100 holding 0xDEADBEEF.
  - `m1_gnt_o` pulses 1 cycle after req.
  - `m1_rvalid_o` pulses 2 cycles later with `m1_rdata_o`=0xDEADBEEF.
  - `owner_o`=1 throughout.
- **Write then read-back:** m0 writes 0x0000_1234 to 0x40, then reads 0x40.
  - `mem_we_o` is high exactly one cycle.
  - The read returns 0x0000_1234.
  - Two rvalid pulses, 2 cycles apart.
- **Starvation (fixed build, `STARVE_LIMIT`=4):** both masters request continuously.
  - Grant order is m0,m0,m0,m0,m1,m0,m0,m0,m0,m1.
  - The counter clears after each m1 win.
- **Round robin (`DMEM_ARB_RR_EN`):** both masters request continuously from reset.
  - Grants alternate m0,m1,m0,m1.
  - Each master receives its own rdata only.
- **Reset mid-access:** assert `rst_ni`=0 during ISSUE of an m0 write.
  - `mem_we_o` goes to 0 asynchronously.
  - No rvalid is seen.
  - After release, all outputs are 0 and the FSM accepts a new m1 read normally.
- **Withdrawn request:** m1 raises req, then lowers it before arbitration while m0 owns the port.
  - No `m1_gnt_o`.
  - No memory access to m1's address.
